// File: rtl/count_seq_checker.sv
// count_seq_checker: receive-side sequence checker for up/down counters.
// Samples a count word, decodes it to one-hot, acquires the count direction,
// then flags every step that breaks the locked sequence.
// Optional build macro: CHK_STALL_ERR_EN (treat a stall in TRACK as a violation).
module count_seq_checker #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  en,
  input  logic [WIDTH-1:0]      cnt_in,
  input  logic                  clear_err,
  output logic [2**WIDTH-1:0]   onehot,
  output logic                  locked,
  output logic                  dir_up,
  output logic                  step_err,
  output logic                  wrap,
  output logic [ERR_W-1:0]      err_count
);

  localparam int N = 2**WIDTH;
  localparam logic [WIDTH-1:0] LOCK_V = WIDTH'(LOCK_CNT);
  localparam logic [WIDTH-1:0] MAX_V  = '1;

  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  prev, prev_n;
  logic [WIDTH-1:0]  run, run_n;
  logic              cand_up, cand_n;
  logic [N-1:0]      onehot_n;
  logic              locked_n, dir_n, step_err_n, wrap_n;
  logic [ERR_W-1:0]  err_n;

  logic [WIDTH-1:0]  diff;
  logic              is_up, is_dn, is_stall, viol;

  assign diff     = cnt_in - prev;
  assign is_up    = (diff == WIDTH'(1));
  assign is_dn    = (diff == MAX_V);
  assign is_stall = (diff == '0);

  // Register every piece of state and every output.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the values present before the edge.
  // NOTE: the asynchronous reset clears all flops immediately; there is no
  // memory array here, so nothing is left un-reset.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      prev      <= '0;
      run       <= '0;
      cand_up   <= 1'b0;
      onehot    <= '0;
      locked    <= 1'b0;
      dir_up    <= 1'b0;
      step_err  <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      run       <= run_n;
      cand_up   <= cand_n;
      onehot    <= onehot_n;
      locked    <= locked_n;
      dir_up    <= dir_n;
      step_err  <= step_err_n;
      wrap      <= wrap_n;
      err_count <= err_n;
    end
  end

  // Next-state, step classification and output decode.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_n    = state;
    prev_n     = prev;
    run_n      = run;
    cand_n     = cand_up;
    onehot_n   = onehot;
    locked_n   = locked;
    dir_n      = dir_up;
    step_err_n = 1'b0;
    wrap_n     = 1'b0;
    viol       = 1'b0;

    if (en) begin
      prev_n   = cnt_in;
      onehot_n = N'(1) << cnt_in;

      unique case (state)
        IDLE: begin
          run_n   = '0;
          state_n = ACQ;
        end

        ACQ: begin
          if (is_up || is_dn) begin
            if (run != '0 && is_up == cand_up) begin
              run_n = run + WIDTH'(1);
            end else begin
              run_n  = WIDTH'(1);
              cand_n = is_up;
            end
            if (run_n == LOCK_V) begin
              state_n  = TRACK;
              locked_n = 1'b1;
              dir_n    = cand_n;
            end
          end else if (!is_stall) begin
            run_n = '0;
          end
        end

        TRACK: begin
          if (dir_up ? is_up : is_dn) begin
            // A legal step leaving the extreme value in the locked direction wraps.
            wrap_n = dir_up ? (prev == MAX_V) : (prev == '0);
          end else if (is_stall) begin
`ifdef CHK_STALL_ERR_EN
            viol = 1'b1;
`else
            viol = 1'b0;
`endif
          end else begin
            viol = 1'b1;
          end

          if (viol) begin
            step_err_n = 1'b1;
            state_n    = ACQ;
            run_n      = '0;
            locked_n   = 1'b0;
          end
        end

        default: state_n = IDLE;
      endcase
    end

    // Saturating error counter; a clear beats a coincident violation.
    err_n = err_count;
    if (clear_err) begin
      err_n = '0;
    end else if (viol && err_count != '1) begin
      err_n = err_count + ERR_W'(1);
    end
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive-side companion to the team's up/down counters.
- Samples a counter's output word and decodes it to one-hot.
- Detects the count direction and locks onto it, then flags every step that breaks the sequence.
- Sits beside any counter under test in lab benches or on-chip self-check. Consumes the count word; drives status and error outputs.

Parameters:
WIDTH, 3, bit width of the sampled count word
LOCK_CNT, 2, consecutive consistent steps required to lock (1..2**WIDTH-1)
ERR_W, 8, width of the saturating error counter

Ports:
CLK  input  1  clock; all sampling and state changes on posedge
Reset  input  1  asynchronous, active-low reset
en  input  1  sample strobe; cnt_in is sampled on posedge CLK when en=1
cnt_in  input  WIDTH  count word from the counter; synchronous to CLK and settled when en=1
clear_err  input  1  synchronous clear of err_count
onehot  output  2**WIDTH  one-hot decode of the last sampled value
locked  output  1  1 while in TRACK
dir_up  output  1  locked direction: 1=up, 0=down; valid only when locked=1
step_err  output  1  one-cycle pulse on a sequence violation in TRACK
wrap  output  1  one-cycle pulse on a legal wrap step in TRACK
err_count  output  ERR_W  number of violations, saturating

Behaviour:
- Reset=0 clears everything asynchronously, regardless of CLK: state=IDLE, prev=0, run=0, onehot=0, locked=0, dir_up=0, step_err=0, wrap=0, err_count=0.
- Reset mid-operation returns the block to IDLE immediately.
- All outputs are registered. A sample taken at edge N appears on the outputs after edge N. step_err and wrap last exactly one cycle.
- en=0: no state change; step_err and wrap are 0; other outputs hold.
- Each sample sets prev=cnt_in and onehot = 1<<cnt_in.
- Step arithmetic: diff = (cnt_in - prev) mod 2**WIDTH.
  - diff=1 is an up step.
  - diff=2**WIDTH-1 is a down step.
  - diff=0 is a stall.
  - Any other diff is invalid.
- IDLE: the first sample stores prev, sets run=0, and moves to ACQ.
- ACQ:
  - Up or down step matching the candidate direction with run>0: run+1.
  - Any other up or down step: run=1, and the candidate direction becomes that step's direction.
  - Invalid step: run=0.
  - Stall: no change.
  - When run reaches LOCK_CNT, move to TRACK with locked=1 and dir_up set to the candidate direction.
  - No errors are counted in ACQ.
- TRACK:
  - A step in the locked direction is legal.
  - wrap pulses on an up step from 2**WIDTH-1 to 0, or on a down step from 0 to 2**WIDTH-1.
  - Opposite-direction or invalid step: step_err pulses, err_count+1, state returns to ACQ with run=0 and locked=0. dir_up holds its last value.
  - Stall: legal (see Optional Feature).
- err_count saturates at 2**ERR_W-1 and does not wrap.
- clear_err=1 sets err_count=0 on the next edge. If it coincides with a violation, the clear wins (err_count=0), but step_err still pulses.
- The step that completes locking does not assert wrap. wrap is only evaluated when the state before the sample is TRACK.

Optional Feature:
- Macro: CHK_STALL_ERR_EN.
- When defined, a stall (diff=0) in TRACK is a violation: step_err pulses, err_count increments, and the state returns to ACQ.
- When undefined, stalls are ignored in every state.

Test Plan:
- Up lock (WIDTH=3, LOCK_CNT=2). en=1 every cycle, cnt_in=0,1,2,3. Required: locked=1 and dir_up=1 in the cycle after the cnt_in=2 sample; onehot=8'h08 after the cnt_in=3 sample; step_err stays 0.
- Down with wrap. cnt_in=2,1,0,7,6. Required: locked=1 and dir_up=0 after the 0 sample; wrap=1 for exactly one cycle after the 7 sample; onehot=8'h80 at that point.
- Violation and relock. Locked up at 4, then cnt_in=6,7,0,1. Required:
  - after 6: step_err=1 (one cycle), err_count=1, locked=0;
  - after 0: locked=1 again (6→7, 7→0);
  - wrap=0 on that locking 7→0 step.
- Stall. Locked up at 3, cnt_in=3 again. Required without CHK_STALL_ERR_EN: no error, locked stays 1. Required with it: step_err=1, err_count+1, locked=0.
- Clear and saturation.
  - ERR_W=2: force 5 violations; err_count holds at 3.
  - Assert clear_err in the same cycle as a violation: err_count=0 and step_err=1.
- Async reset. Pull Reset low mid-TRACK between clock edges. Required: all outputs 0 immediately. After release, the first sample causes no error and the block enters ACQ.
